// File: rtl/lpc_host.sv
// LPC host: issues single I/O read/write cycles on LAD/LFRAME# and decodes LDRQ#
// DMA request frames into per-channel request levels.
module lpc_host #(
  parameter int WAIT_LIMIT  = 1023,
  parameter int SHORT_LIMIT = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rdata,
  output logic [1:0]  status,
  output logic        LPC_FRM,
  inout  wire  [3:0]  LPC_DATA,
  input  logic        LPC_DREQ,
  output logic [7:0]  dreq
);

  // state | meaning
  // IDLE  | bus released, accepting req       START | LFRAME# low, LAD=0
  // CTDIR | cycle type / direction nibble     ADDR  | four address nibbles
  // WDATA | write data low then high nibble   TAR1  | host drives F
  // TAR2  | host releases LAD                 SYNC  | sample responder SYNC
  // RDATA | read data low then high nibble    RTAR  | two released cycles
  // ABORT | LFRAME# low, LAD=F for 4 cycles   AEND  | one released cycle
  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_START = 4'd1;
  localparam logic [3:0] S_CTDIR = 4'd2;
  localparam logic [3:0] S_ADDR  = 4'd3;
  localparam logic [3:0] S_WDATA = 4'd4;
  localparam logic [3:0] S_TAR1  = 4'd5;
  localparam logic [3:0] S_TAR2  = 4'd6;
  localparam logic [3:0] S_SYNC  = 4'd7;
  localparam logic [3:0] S_RDATA = 4'd8;
  localparam logic [3:0] S_RTAR  = 4'd9;
  localparam logic [3:0] S_ABORT = 4'd10;
  localparam logic [3:0] S_AEND  = 4'd11;

  localparam logic [1:0] DQ_IDLE = 2'd0;
  localparam logic [1:0] DQ_CHAN = 2'd1;
  localparam logic [1:0] DQ_ACT  = 2'd2;

  localparam int LW = $clog2(WAIT_LIMIT + 2);
  localparam int SW = $clog2(SHORT_LIMIT + 2);
  localparam logic [LW-1:0] LONG_MAX  = LW'(WAIT_LIMIT);
  localparam logic [SW-1:0] SHORT_MAX = SW'(SHORT_LIMIT);

  logic [3:0]    r_state;
  logic [1:0]    r_idx;
  logic          r_write;
  logic [15:0]   r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdata;
  logic          r_done;
  logic          r_err;
  logic [1:0]    r_status;
  logic [LW-1:0] r_long;
  logic [SW-1:0] r_short;
  logic [1:0]    r_nores;
  logic [1:0]    r_dq_state;
  logic [1:0]    r_dq_cnt;
  logic [2:0]    r_dq_ch;
  logic [7:0]    r_dreq;
  logic          w_frm;
  logic          w_oe;
  logic [3:0]    w_lad;
  logic [3:0]    w_sync;

  assign w_sync = LPC_DATA;

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_write  <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_status <= '0;
      r_long   <= '0;
      r_short  <= '0;
      r_nores  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (req) begin
          r_write <= req_write;
          r_addr  <= req_addr;
          r_wdata <= req_wdata;
          r_rdata <= '0;
          r_err   <= 1'b0;
          r_state <= S_START;
        end
        S_START: r_state <= S_CTDIR;
        S_CTDIR: begin
          r_idx   <= '0;
          r_state <= S_ADDR;
        end
        S_ADDR: begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= r_write ? S_WDATA : S_TAR1;
        end
        S_WDATA: begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd1) begin
            r_idx   <= '0;
            r_state <= S_TAR1;
          end
        end
        S_TAR1: r_state <= S_TAR2;
        S_TAR2: begin
          r_long  <= '0;
          r_short <= '0;
          r_nores <= '0;
          r_state <= S_SYNC;
        end
        S_SYNC: begin
          // each wait counter only survives a run of its own SYNC code
          r_long  <= '0;
          r_short <= '0;
          r_nores <= '0;
          r_idx   <= '0;
          case (w_sync)
            4'h0, 4'hA: begin
              r_err   <= (w_sync == 4'hA);
              r_state <= r_write ? S_RTAR : S_RDATA;
            end
            4'h6: if (r_long == LONG_MAX) begin
              r_status <= 2'd3;
              r_state  <= S_ABORT;
            end else r_long <= r_long + 1'b1;
            4'h5: if (r_short == SHORT_MAX) begin
              r_status <= 2'd3;
              r_state  <= S_ABORT;
            end else r_short <= r_short + 1'b1;
            4'hF: if (r_nores == 2'd2) begin
              r_status <= 2'd2;
              r_state  <= S_ABORT;
            end else r_nores <= r_nores + 2'd1;
            default: begin
              r_status <= 2'd2;
              r_state  <= S_ABORT;
            end
          endcase
        end
        S_RDATA: begin
          if (r_idx == 2'd0) begin
            r_rdata[3:0] <= w_sync;
            r_idx        <= 2'd1;
          end else begin
            r_rdata[7:4] <= w_sync;
            r_idx        <= '0;
            r_state      <= S_RTAR;
          end
        end
        S_RTAR: begin
          if (r_idx == 2'd1) begin
            r_idx    <= '0;
            r_done   <= 1'b1;
            r_status <= r_err ? 2'd1 : 2'd0;
            r_state  <= S_IDLE;
          end else r_idx <= 2'd1;
        end
        S_ABORT: begin
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= S_AEND;
        end
        S_AEND: begin
          r_rdata <= '0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_frm = 1'b1;
    w_oe  = 1'b0;
    w_lad = 4'h0;
    case (r_state)
      S_START: begin
        w_frm = 1'b0;
        w_oe  = 1'b1;
      end
      S_CTDIR: begin
        w_oe  = 1'b1;
        w_lad = r_write ? 4'h2 : 4'h0;
      end
      S_ADDR: begin
        w_oe = 1'b1;
        case (r_idx)
          2'd0:    w_lad = r_addr[15:12];
          2'd1:    w_lad = r_addr[11:8];
          2'd2:    w_lad = r_addr[7:4];
          default: w_lad = r_addr[3:0];
        endcase
      end
      S_WDATA: begin
        w_oe  = 1'b1;
        w_lad = (r_idx == 2'd0) ? r_wdata[3:0] : r_wdata[7:4];
      end
      S_TAR1: begin
        w_oe  = 1'b1;
        w_lad = 4'hF;
      end
      S_ABORT: begin
        w_frm = 1'b0;
        w_oe  = 1'b1;
        w_lad = 4'hF;
      end
      default: ;
    endcase
  end

  assign LPC_FRM  = w_frm;
  assign LPC_DATA = w_oe ? w_lad : 4'bzzzz;
  assign busy     = (r_state != S_IDLE);
  assign done     = r_done;
  assign rdata    = r_rdata;
  assign status   = r_status;
  assign dreq     = r_dreq;

  // LDRQ# frame: start bit 0, channel MSB first, then ACT
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_dq_state <= DQ_IDLE;
      r_dq_cnt   <= '0;
      r_dq_ch    <= '0;
      r_dreq     <= '0;
    end else begin
      case (r_dq_state)
        DQ_IDLE: if (!LPC_DREQ) begin
          r_dq_cnt   <= '0;
          r_dq_state <= DQ_CHAN;
        end
        DQ_CHAN: begin
          r_dq_ch  <= {r_dq_ch[1:0], LPC_DREQ};
          r_dq_cnt <= r_dq_cnt + 2'd1;
          if (r_dq_cnt == 2'd2) r_dq_state <= DQ_ACT;
        end
        DQ_ACT: begin
          r_dreq[r_dq_ch] <= LPC_DREQ;
          r_dq_state      <= DQ_IDLE;
        end
        default: r_dq_state <= DQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lpc_host.sv
// Bench for lpc_host: table of I/O cycles with a cycle-accurate bus trace and a
// done scoreboard, plus LDRQ and reset corner sequences.
module tb_lpc_host;

  logic        CLK = 1'b0;
  logic        reset;
  logic        req;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        busy;
  logic        done;
  logic [7:0]  rdata;
  logic [1:0]  status;
  logic        LPC_FRM;
  wire  [3:0]  lad;
  logic        LPC_DREQ;
  logic [7:0]  dreq;

  logic        tb_en;
  logic [3:0]  tb_val;
  assign lad = tb_en ? tb_val : 4'bzzzz;

  lpc_host dut (
    .CLK(CLK), .reset(reset), .req(req), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .busy(busy), .done(done),
    .rdata(rdata), .status(status), .LPC_FRM(LPC_FRM), .LPC_DATA(lad),
    .LPC_DREQ(LPC_DREQ), .dreq(dreq)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit         wr;
    logic [15:0] addr;
    logic [7:0] wdata;
    int         na; logic [3:0] ca;
    int         nb; logic [3:0] cb;
    int         nc; logic [3:0] cc;
    bit         abrt;
    logic [3:0] send;
    logic [7:0] rd;
    logic [1:0] st;
    logic [7:0] rdx;
    int         len;
    int         hold;
  } vec_t;

  typedef struct { bit frm; logic [3:0] lad; bit en; } step_t;
  typedef struct { logic [1:0] st; logic [7:0] rd; int cyc; } exp_t;

  int     n_tests = 0;
  int     n_fail  = 0;
  int     cyc     = 0;
  bit     mon_en  = 1'b0;
  exp_t   sb[$];
  step_t  tr[$];
  vec_t   vecs[13];
  logic [7:0] dq_exp;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    if (mon_en && done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("status", {30'd0, status}, {30'd0, e.st});
        chk("rdata", {24'd0, rdata}, {24'd0, e.rd});
      end
    end
  end

  function automatic void add(bit frm, logic [3:0] l, bit en);
    step_t s;
    s.frm = frm; s.lad = l; s.en = en;
    tr.push_back(s);
  endfunction

  function automatic void build_trace(input vec_t v);
    tr.delete();
    add(1'b0, 4'h0, 1'b0);
    add(1'b1, v.wr ? 4'h2 : 4'h0, 1'b0);
    add(1'b1, v.addr[15:12], 1'b0);
    add(1'b1, v.addr[11:8], 1'b0);
    add(1'b1, v.addr[7:4], 1'b0);
    add(1'b1, v.addr[3:0], 1'b0);
    if (v.wr) begin
      add(1'b1, v.wdata[3:0], 1'b0);
      add(1'b1, v.wdata[7:4], 1'b0);
    end
    add(1'b1, 4'hF, 1'b0);
    add(1'b1, 4'h0, 1'b1);
    repeat (v.na) add(1'b1, v.ca, 1'b1);
    repeat (v.nb) add(1'b1, v.cb, 1'b1);
    repeat (v.nc) add(1'b1, v.cc, 1'b1);
    if (!v.abrt) begin
      add(1'b1, v.send, 1'b1);
      if (!v.wr) begin
        add(1'b1, v.rd[3:0], 1'b1);
        add(1'b1, v.rd[7:4], 1'b1);
      end
      add(1'b1, 4'h0, 1'b1);
      add(1'b1, 4'h0, 1'b1);
    end else begin
      repeat (4) add(1'b0, 4'hF, 1'b0);
      add(1'b1, 4'h0, 1'b1);
    end
  endfunction

  // entered and left at 1 time unit after a rising edge with the host idle
  task automatic do_io(input vec_t v, input string nm);
    int   start;
    exp_t e;
    build_trace(v);
    req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req = 1'b1;
    @(posedge CLK); #1;
    start = cyc;
    e.st = v.st; e.rd = v.rdx; e.cyc = start + v.len;
    sb.push_back(e);
    req_addr = ~v.addr; req_wdata = ~v.wdata; req_write = ~v.wr;
    if (v.hold == 0) req = 1'b0;
    foreach (tr[i]) begin
      if (i == v.hold) req = 1'b0;
      tb_en = tr[i].en; tb_val = tr[i].lad;
      @(negedge CLK);
      chk($sformatf("%s frm[%0d]", nm, i), {31'd0, LPC_FRM}, {31'd0, tr[i].frm});
      chk($sformatf("%s lad[%0d]", nm, i), {28'd0, lad}, {28'd0, tr[i].lad});
      chk($sformatf("%s busy[%0d]", nm, i), {31'd0, busy}, 32'd1);
      @(posedge CLK); #1;
    end
    req = 1'b0; tb_en = 1'b1; tb_val = 4'h0;
    @(negedge CLK);
    chk($sformatf("%s busy_at_done", nm), {31'd0, busy}, 32'd0);
    @(posedge CLK); #1;
    @(negedge CLK);
    chk($sformatf("%s busy_after", nm), {31'd0, busy}, 32'd0);
    chk($sformatf("%s done_seen", nm), sb.size(), 32'd0);
    sb.delete();
    @(posedge CLK); #1;
  endtask

  task automatic ldrq_frame(input logic [2:0] ch, input logic act);
    LPC_DREQ = 1'b0;
    @(posedge CLK); #1;
    for (int b = 2; b >= 0; b--) begin
      LPC_DREQ = ch[b];
      @(posedge CLK); #1;
    end
    LPC_DREQ = act;
    @(posedge CLK); #1;
    LPC_DREQ = 1'b1;
    dq_exp[ch] = act;
    @(negedge CLK);
    chk($sformatf("dreq ch%0d", ch), {24'd0, dreq}, {24'd0, dq_exp});
    @(posedge CLK); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //          wr    addr      wdata  na  ca     nb  cb     nc  cc     abrt  send   rd     st    rdx    len   hold
    vecs[0]  = '{1'b1, 16'h0246, 8'h5A, 0,    4'h0, 0, 4'h0, 0, 4'h0, 1'b0, 4'h0, 8'h00, 2'd0, 8'h00, 13,   0};
    vecs[1]  = '{1'b0, 16'h0342, 8'h00, 3,    4'h6, 0, 4'h0, 0, 4'h0, 1'b0, 4'h0, 8'hC7, 2'd0, 8'hC7, 16,   0};
    vecs[2]  = '{1'b0, 16'h0080, 8'h00, 3,    4'hF, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0, 8'h00, 2'd2, 8'h00, 16,   0};
    vecs[3]  = '{1'b0, 16'h0100, 8'h00, 9,    4'h5, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0, 8'h00, 2'd3, 8'h00, 22,   0};
    vecs[4]  = '{1'b1, 16'h1234, 8'hA5, 0,    4'h0, 0, 4'h0, 0, 4'h0, 1'b0, 4'hA, 8'h00, 2'd1, 8'h00, 13,   5};
    vecs[5]  = '{1'b0, 16'hABCD, 8'h00, 8,    4'h5, 0, 4'h0, 0, 4'h0, 1'b0, 4'h0, 8'h3C, 2'd0, 8'h3C, 21,   0};
    vecs[6]  = '{1'b1, 16'hFFFF, 8'h00, 2,    4'hF, 0, 4'h0, 0, 4'h0, 1'b0, 4'h0, 8'h00, 2'd0, 8'h00, 15,   0};
    vecs[7]  = '{1'b0, 16'h8001, 8'h00, 1023, 4'h6, 0, 4'h0, 0, 4'h0, 1'b0, 4'h0, 8'hA5, 2'd0, 8'hA5, 1036, 0};
    vecs[8]  = '{1'b0, 16'h0F0F, 8'h00, 1024, 4'h6, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0, 8'h00, 2'd3, 8'h00, 1037, 0};
    vecs[9]  = '{1'b1, 16'h55AA, 8'h81, 1,    4'h3, 0, 4'h0, 0, 4'h0, 1'b1, 4'h0, 8'h00, 2'd2, 8'h00, 16,   0};
    vecs[10] = '{1'b0, 16'h1357, 8'h00, 8,    4'h5, 1, 4'h6, 8, 4'h5, 1'b0, 4'h0, 8'h96, 2'd0, 8'h96, 30,   0};
    vecs[11] = '{1'b1, 16'h2468, 8'h3C, 2,    4'hF, 1, 4'h5, 2, 4'hF, 1'b0, 4'h0, 8'h00, 2'd0, 8'h00, 18,   0};
    vecs[12] = '{1'b0, 16'h00FF, 8'h00, 2,    4'h6, 0, 4'h0, 0, 4'h0, 1'b0, 4'hA, 8'h5E, 2'd1, 8'h5E, 15,   0};

    reset = 1'b1; req = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    LPC_DREQ = 1'b1; tb_en = 1'b1; tb_val = 4'h0; dq_exp = 8'h00;
    repeat (2) @(posedge CLK);
    #1 reset = 1'b0;
    @(negedge CLK);
    chk("rst frm", {31'd0, LPC_FRM}, 32'd1);
    chk("rst lad", {28'd0, lad}, 32'd0);
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst rdata", {24'd0, rdata}, 32'd0);
    chk("rst status", {30'd0, status}, 32'd0);
    chk("rst dreq", {24'd0, dreq}, 32'd0);
    mon_en = 1'b1;
    @(posedge CLK); #1;

    foreach (vecs[i]) do_io(vecs[i], $sformatf("vec%0d", i));

    // LDRQ frames back to back while an I/O read runs
    fork
      do_io(vecs[1], "ldrq_io");
      begin
        ldrq_frame(3'd1, 1'b1);
        ldrq_frame(3'd1, 1'b0);
      end
    join
    ldrq_frame(3'd7, 1'b1);
    ldrq_frame(3'd5, 1'b1);

    // reset in the middle of the address phase
    req_write = 1'b0; req_addr = 16'h0342; req = 1'b1;
    @(posedge CLK); #1;
    req = 1'b0; tb_en = 1'b0;
    repeat (3) begin @(posedge CLK); #1; end
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0; tb_en = 1'b1; tb_val = 4'h0; dq_exp = 8'h00;
    @(negedge CLK);
    chk("midrst frm", {31'd0, LPC_FRM}, 32'd1);
    chk("midrst lad", {28'd0, lad}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst status", {30'd0, status}, 32'd0);
    chk("midrst dreq", {24'd0, dreq}, 32'd0);
    repeat (16) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("midrst no_done", {31'd0, done}, 32'd0);
    end
    @(posedge CLK); #1;
    do_io(vecs[0], "after_rst");

    // reset part-way through an LDRQ frame
    LPC_DREQ = 1'b0;
    @(posedge CLK); #1;
    LPC_DREQ = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b1;
    @(posedge CLK); #1;
    reset = 1'b0; dq_exp = 8'h00;
    @(negedge CLK);
    chk("ldrq_rst dreq", {24'd0, dreq}, 32'd0);
    @(posedge CLK); #1;
    ldrq_frame(3'd3, 1'b1);
    ldrq_frame(3'd6, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
